// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-style PIC acknowledge sequencer.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        GAP  = 2'd2,
        ACK2 = 2'd3
    } state_t;

    localparam logic [2:0] SPURIOUS_LVL = 3'd7;

    function automatic logic [7:0] onehot8(input logic [2:0] lvl);
        onehot8 = 8'd1 << lvl;
    endfunction

endpackage

// File: rtl/pic_inta_edge.sv
// INTA edge detector: one register of history gives fall/rise strobes.
module pic_inta_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic inta_n,
    output logic fall,
    output logic rise
);

    logic prev;

    // Resets high so an idle (high) INTA line produces no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= inta_n;
    end

    assign fall = prev & ~inta_n;
    assign rise = ~prev & inta_n;

endmodule

// File: rtl/pic_inta_sequencer.sv
// Two-pulse 8086-mode INTA sequencer: freezes the resolver, commits the ISR
// bit, drives the vector byte and handles AEOI, spurious and aborted cycles.
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inta_n,
    input  logic       int_req,
    input  logic [2:0] int_vec,
    input  logic [4:0] icw2_base,
    input  logic       aeoi_mode,
    output logic       int_out,
    output logic       freeze,
    output logic [7:0] isr_set,
    output logic [7:0] isr_clr,
    output logic [7:0] dout,
    output logic       dout_en,
    output logic       spurious,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [2:0]       lvl;
    logic             spur;
    logic [CNT_W-1:0] cnt;
    logic             fall;
    logic             rise;

    pic_inta_edge u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .inta_n (inta_n),
        .fall   (fall),
        .rise   (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lvl      <= 3'd0;
            spur     <= 1'b0;
            cnt      <= '0;
            int_out  <= 1'b0;
            freeze   <= 1'b0;
            isr_set  <= 8'd0;
            isr_clr  <= 8'd0;
            dout     <= 8'd0;
            dout_en  <= 1'b0;
            spurious <= 1'b0;
            busy     <= 1'b0;
        end else begin
            isr_set  <= 8'd0;
            isr_clr  <= 8'd0;
            spurious <= 1'b0;
            int_out  <= 1'b0;
            unique case (state)
                IDLE: begin
                    int_out <= int_req & ~fall;
                    if (fall) begin
                        lvl      <= int_req ? int_vec : SPURIOUS_LVL;
                        spur     <= ~int_req;
                        isr_set  <= int_req ? onehot8(int_vec) : 8'd0;
                        spurious <= ~int_req;
                        freeze   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ACK1;
                    end
                end
                ACK1: begin
                    if (rise) begin
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (fall) begin
                        dout    <= {icw2_base, lvl};
                        dout_en <= 1'b1;
                        state   <= ACK2;
                    end else if (cnt == CNT_LAST) begin
                        // Aborted acknowledge: ISR bit stays set for software EOI.
                        freeze <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK2: begin
                    if (rise) begin
                        dout    <= 8'd0;
                        dout_en <= 1'b0;
                        freeze  <= 1'b0;
                        busy    <= 1'b0;
                        isr_clr <= (aeoi_mode && !spur) ? onehot8(lvl) : 8'd0;
                        state   <= IDLE;
                    end else begin
                        dout <= {icw2_base, lvl};
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: directed scenarios plus
// randomized acknowledge transactions against a transaction-level model.
module tb_pic_inta_sequencer;

    localparam int T = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inta_n;
    logic       int_req;
    logic [2:0] int_vec;
    logic [4:0] icw2_base;
    logic       aeoi_mode;
    logic       int_out;
    logic       freeze;
    logic [7:0] isr_set;
    logic [7:0] isr_clr;
    logic [7:0] dout;
    logic       dout_en;
    logic       spurious;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Level -> ISR bit lookup, written out rather than computed.
    logic [7:0] bit_of [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                               8'h10, 8'h20, 8'h40, 8'h80};

    pic_inta_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inta_n    (inta_n),
        .int_req   (int_req),
        .int_vec   (int_vec),
        .icw2_base (icw2_base),
        .aeoi_mode (aeoi_mode),
        .int_out   (int_out),
        .freeze    (freeze),
        .isr_set   (isr_set),
        .isr_clr   (isr_clr),
        .dout      (dout),
        .dout_en   (dout_en),
        .spurious  (spurious),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; inta_n = 1'b1; int_req = 1'b0; int_vec = 3'd0;
        icw2_base = 5'd0; aeoi_mode = 1'b0;
        #3;
        n_cmp++;
        if ({int_out, freeze, isr_set, isr_clr, dout, dout_en, spurious, busy} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dout=%h en=%b frz=%b busy=%b set=%h clr=%h",
                     dout, dout_en, freeze, busy, isr_set, isr_clr);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One full two-pulse acknowledge; expectations come from the level rules.
    task automatic run_ack(input bit req, input logic [2:0] vec, input logic [4:0] base,
                           input bit aeoi, input int p1, input int g, input int p2,
                           input bit chg, input string tag);
        logic [2:0] lvl;
        logic [7:0] exp_set, exp_clr, exp_dout;
        lvl      = req ? vec : 3'd7;
        exp_set  = req ? bit_of[lvl] : 8'h00;
        exp_clr  = (req && aeoi) ? bit_of[lvl] : 8'h00;
        exp_dout = {base, lvl};
        int_req = req; int_vec = vec; icw2_base = base; aeoi_mode = aeoi;
        tick(); tick();
        n_cmp++;
        if (int_out !== req) begin
            n_fail++; $display("FAIL %s int_out_idle: got %b want %b", tag, int_out, req);
        end
        inta_n = 1'b0;
        tick();
        n_cmp++;
        if (isr_set !== exp_set || spurious !== !req || freeze !== 1'b1 ||
            int_out !== 1'b0 || busy !== 1'b1 || dout_en !== 1'b0 || isr_clr !== 8'h00) begin
            n_fail++;
            $display("FAIL %s pulse1: set=%h sp=%b frz=%b int=%b busy=%b en=%b want set=%h sp=%b",
                     tag, isr_set, spurious, freeze, int_out, busy, dout_en, exp_set, !req);
        end
        for (int i = 1; i < p1; i++) begin
            tick();
            n_cmp++;
            if (isr_set !== 8'h00 || spurious !== 1'b0 || freeze !== 1'b1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s ack1_hold: set=%h sp=%b frz=%b busy=%b", tag, isr_set,
                         spurious, freeze, busy);
            end
        end
        inta_n = 1'b1;
        if (chg) begin
            int_vec = 3'd5;
            int_req = 1'($urandom_range(0, 1));
        end
        tick();
        for (int i = 0; i <= g; i++) begin
            n_cmp++;
            if (dout_en !== 1'b0 || freeze !== 1'b1 || busy !== 1'b1 || int_out !== 1'b0) begin
                n_fail++;
                $display("FAIL %s gap: en=%b frz=%b busy=%b int=%b", tag, dout_en, freeze,
                         busy, int_out);
            end
            if (i < g) tick();
        end
        inta_n = 1'b0;
        tick();
        for (int i = 0; i < p2; i++) begin
            n_cmp++;
            if (dout !== exp_dout || dout_en !== 1'b1 || freeze !== 1'b1) begin
                n_fail++;
                $display("FAIL %s pulse2: dout=%h en=%b frz=%b want dout=%h", tag, dout,
                         dout_en, freeze, exp_dout);
            end
            if (i < p2 - 1) tick();
        end
        inta_n = 1'b1;
        tick();
        n_cmp++;
        if (dout !== 8'h00 || dout_en !== 1'b0 || freeze !== 1'b0 || busy !== 1'b0 ||
            isr_clr !== exp_clr || isr_set !== 8'h00) begin
            n_fail++;
            $display("FAIL %s release: dout=%h en=%b frz=%b busy=%b clr=%h want clr=%h",
                     tag, dout, dout_en, freeze, busy, isr_clr, exp_clr);
        end
        tick();
        n_cmp++;
        if (isr_clr !== 8'h00 || int_out !== int_req) begin
            n_fail++;
            $display("FAIL %s after: clr=%h int=%b want int=%b", tag, isr_clr, int_out, int_req);
        end
    endtask

    task automatic test_normal();
        run_ack(1'b1, 3'd3, 5'b01000, 1'b0, 2, 3, 2, 1'b0, "normal");
    endtask

    task automatic test_aeoi();
        run_ack(1'b1, 3'd3, 5'b01000, 1'b1, 1, 0, 1, 1'b0, "aeoi");
    endtask

    task automatic test_spurious();
        run_ack(1'b0, 3'd2, 5'b10101, 1'b1, 2, 2, 3, 1'b0, "spurious");
    endtask

    task automatic test_request_change();
        run_ack(1'b1, 3'd0, 5'b00110, 1'b0, 1, 4, 2, 1'b1, "req_change");
    endtask

    task automatic test_timeout();
        int_req = 1'b1; int_vec = 3'd2; icw2_base = 5'd3; aeoi_mode = 1'b0;
        tick();
        inta_n = 1'b0;
        tick();
        inta_n = 1'b1;
        tick();
        for (int i = 0; i < T - 1; i++) tick();
        n_cmp++;
        if (busy !== 1'b1 || freeze !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: busy=%b frz=%b want 1 1", busy, freeze);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || freeze !== 1'b0 || dout_en !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: busy=%b frz=%b en=%b want 0 0 0", busy, freeze, dout_en);
        end
        run_ack(1'b1, 3'd6, 5'd3, 1'b0, 1, 1, 1, 1'b0, "post_timeout");
    endtask

    task automatic test_reset_mid_ack2();
        int_req = 1'b1; int_vec = 3'd4; icw2_base = 5'd9; aeoi_mode = 1'b1;
        tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        n_cmp++;
        if (dout_en !== 1'b1 || dout !== {5'd9, 3'd4}) begin
            n_fail++;
            $display("FAIL rst_mid_pre: en=%b dout=%h want 1 %h", dout_en, dout, {5'd9, 3'd4});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dout_en !== 1'b0 || dout !== 8'h00 || freeze !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: en=%b dout=%h frz=%b busy=%b want all 0",
                     dout_en, dout, freeze, busy);
        end
        inta_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_ack(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 3), $urandom_range(0, 40), $urandom_range(1, 3),
                    1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_back_to_back();
        run_ack(1'b1, 3'd1, 5'd17, 1'b1, 1, 0, 1, 1'b0, "b2b_a");
        run_ack(1'b1, 3'd7, 5'd17, 1'b1, 1, 0, 1, 1'b0, "b2b_b");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_aeoi();
        test_spurious();
        test_request_change();
        test_timeout();
        test_reset_mid_ack2();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
